// File: rtl/j_fdsync_bank.sv
// Bank of independent load-enable holding registers. Each channel synchronises its own
// load strobe, qualifies it by level or rising edge, and reports ack/upd/pend/ovr.
module j_fdsync_bank #(
  parameter int             WIDTH       = 1,
  parameter int             CHANNELS    = 1,
  parameter int             SYNC_STAGES = 2,
  parameter bit             EDGE        = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       ld,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS-1:0]       upd,
  output logic [CHANNELS-1:0]       pend,
  output logic [CHANNELS-1:0]       ovr
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             w_ld_s;
      logic             w_load;
      logic             r_ld_prev;
      logic             r_upd;
      logic             r_pend;
      logic             r_ovr;
      logic [WIDTH-1:0] r_q;

      if (SYNC_STAGES == 0) begin : g_nosync
        assign w_ld_s = ld[gi];
      end else begin : g_sync
        // Plain flop chain: no logic between stages so each stage can resolve metastability.
        logic [SYNC_STAGES-1:0] r_sync;
        always_ff @(posedge sys_clk or posedge reset) begin
          if (reset) begin
            r_sync <= '0;
          end else begin
            r_sync[0] <= ld[gi];
            for (int i = 1; i < SYNC_STAGES; i++) begin
              r_sync[i] <= r_sync[i-1];
            end
          end
        end
        assign w_ld_s = r_sync[SYNC_STAGES-1];
      end

      assign w_load = EDGE ? (w_ld_s & ~r_ld_prev) : w_ld_s;

      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
          r_q       <= RESET_VAL;
          r_ld_prev <= 1'b0;
          r_upd     <= 1'b0;
          r_pend    <= 1'b0;
          r_ovr     <= 1'b0;
        end else begin
          r_ld_prev <= w_ld_s;
          r_upd     <= w_load;
          if (w_load) begin
            r_q <= d[gi*WIDTH +: WIDTH];
          end
          // A load always wins over clr for pend; clr always wins for ovr.
          if (w_load) begin
            r_pend <= 1'b1;
          end else if (clr[gi]) begin
            r_pend <= 1'b0;
          end
          if (clr[gi]) begin
            r_ovr <= 1'b0;
          end else if (w_load && r_pend) begin
            r_ovr <= 1'b1;
          end
        end
      end

      assign q[gi*WIDTH +: WIDTH] = r_q;
      assign ack[gi]              = r_ld_prev;
      assign upd[gi]              = r_upd;
      assign pend[gi]             = r_pend;
      assign ovr[gi]              = r_ovr;
    end
  endgenerate

endmodule

// File: tb/tb_j_fdsync_bank.sv
// Directed checks of j_fdsync_bank across four parameter sets, plus a 4-phase traffic run
// on a four-channel bank with a per-channel expected-value record.
module tb_j_fdsync_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // A: W=8, CH=2, S=2, EDGE=1, RESET_VAL=A5
  logic        a_rst;
  logic [15:0] a_d, a_q;
  logic [1:0]  a_ld, a_clr, a_ack, a_upd, a_pend, a_ovr;
  // B: W=8, CH=1, S=2, EDGE=0
  logic        b_rst;
  logic [7:0]  b_d, b_q;
  logic [0:0]  b_ld, b_clr, b_ack, b_upd, b_pend, b_ovr;
  // C: W=8, CH=1, S=0, EDGE=0
  logic [7:0]  c_d, c_q;
  logic [0:0]  c_ld, c_clr, c_ack, c_upd, c_pend, c_ovr;
  // D: W=8, CH=4, S=3, EDGE=1
  logic        d_rst;
  logic [31:0] d_d, d_q;
  logic [3:0]  d_ld, d_clr, d_ack, d_upd, d_pend, d_ovr;

  j_fdsync_bank #(.WIDTH(8), .CHANNELS(2), .SYNC_STAGES(2), .EDGE(1'b1), .RESET_VAL(8'hA5)) u_a (
    .sys_clk(clk), .reset(a_rst), .d(a_d), .ld(a_ld), .clr(a_clr),
    .q(a_q), .ack(a_ack), .upd(a_upd), .pend(a_pend), .ovr(a_ovr));
  j_fdsync_bank #(.WIDTH(8), .CHANNELS(1), .SYNC_STAGES(2), .EDGE(1'b0), .RESET_VAL(8'h00)) u_b (
    .sys_clk(clk), .reset(b_rst), .d(b_d), .ld(b_ld), .clr(b_clr),
    .q(b_q), .ack(b_ack), .upd(b_upd), .pend(b_pend), .ovr(b_ovr));
  j_fdsync_bank #(.WIDTH(8), .CHANNELS(1), .SYNC_STAGES(0), .EDGE(1'b0), .RESET_VAL(8'h00)) u_c (
    .sys_clk(clk), .reset(b_rst), .d(c_d), .ld(c_ld), .clr(c_clr),
    .q(c_q), .ack(c_ack), .upd(c_upd), .pend(c_pend), .ovr(c_ovr));
  j_fdsync_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(3), .EDGE(1'b1), .RESET_VAL(8'h00)) u_d (
    .sys_clk(clk), .reset(d_rst), .d(d_d), .ld(d_ld), .clr(d_clr),
    .q(d_q), .ack(d_ack), .upd(d_upd), .pend(d_pend), .ovr(d_ovr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 4-phase load on A channel 0; optionally raise clr so it lands on the load edge.
  task automatic a_load0(input logic [7:0] v, input bit clr_at_load);
    a_d[7:0] = v;
    a_ld[0]  = 1'b1;
    tick();
    tick();
    if (clr_at_load) a_clr[0] = 1'b1;
    tick();
    a_clr[0] = 1'b0;
    chk("a_load_q", {24'h0, a_q[7:0]}, {24'h0, v});
    chk("a_load_upd", {31'h0, a_upd[0]}, 32'h1);
    a_ld[0] = 1'b0;
    repeat (3) tick();
    chk("a_load_ack_low", {31'h0, a_ack[0]}, 32'h0);
  endtask

  int          st[4];
  int          wcnt[4];
  int          n_req[4];
  int          n_upd[4];
  logic [7:0]  exp_q[4];
  int          n_edge;
  int          n_lvl;

  initial begin
    a_rst = 1'b1; a_d = '0; a_ld = '0; a_clr = '0;
    b_rst = 1'b1; b_d = '0; b_ld = '0; b_clr = '0;
    c_d = '0; c_ld = '0; c_clr = '0;
    d_rst = 1'b1; d_d = 32'h0000_00C3; d_ld = 4'b0001; d_clr = '0;
    tick();
    tick();
    chk("rst_a_q", {16'h0, a_q}, 32'h0000_A5A5);
    chk("rst_a_flags", {24'h0, a_ack, a_upd, a_pend, a_ovr}, 32'h0);
    chk("rst_d_q", d_q, 32'h0);

    // ld[0] is already high; the first edge after release is its first sampling edge.
    d_rst = 1'b0;
    tick(); tick(); tick();
    chk("rel_q_before", d_q, 32'h0);
    tick();
    chk("rel_q_loaded", d_q, 32'h0000_00C3);
    chk("rel_upd", {28'h0, d_upd}, 32'h1);
    n_edge = 0;
    repeat (8) begin
      tick();
      if (d_upd[0]) n_edge++;
    end
    chk("rel_extra_loads", n_edge, 0);
    d_ld[0] = 1'b0;
    repeat (4) tick();
    chk("rel_ack_low", {28'h0, d_ack}, 32'h0);

    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) tick();

    // Latency: ld sampled at E1, visible after E3.
    a_d = 16'h773C;
    a_ld[0] = 1'b1;
    tick();
    chk("lat_e1_q", {16'h0, a_q}, 32'h0000_A5A5);
    tick();
    chk("lat_e2_q", {16'h0, a_q}, 32'h0000_A5A5);
    chk("lat_e2_ack", {30'h0, a_ack}, 32'h0);
    tick();
    chk("lat_e3_q", {16'h0, a_q}, 32'h0000_A53C);
    chk("lat_e3_upd", {30'h0, a_upd}, 32'h1);
    chk("lat_e3_ack", {30'h0, a_ack}, 32'h1);
    chk("lat_e3_pend", {30'h0, a_pend}, 32'h1);
    a_ld[0] = 1'b0;
    tick();
    chk("lat_e4_upd", {30'h0, a_upd}, 32'h0);
    chk("lat_e4_ack", {30'h0, a_ack}, 32'h1);
    tick();
    chk("lat_e5_ack", {30'h0, a_ack}, 32'h1);
    tick();
    chk("lat_e6_ack", {30'h0, a_ack}, 32'h0);

    // Asynchronous reset mid-cycle.
    #3 a_rst = 1'b1;
    #1;
    chk("async_rst_q", {16'h0, a_q}, 32'h0000_A5A5);
    chk("async_rst_flags", {24'h0, a_ack, a_upd, a_pend, a_ovr}, 32'h0);
    tick();
    a_rst = 1'b0;
    tick();

    // Flags.
    a_load0(8'h11, 1'b0);
    chk("flag1", {30'h0, a_pend[0], a_ovr[0]}, 32'h2);
    a_load0(8'h22, 1'b0);
    chk("flag2", {30'h0, a_pend[0], a_ovr[0]}, 32'h3);
    a_clr[0] = 1'b1;
    tick();
    a_clr[0] = 1'b0;
    chk("flag_clr", {30'h0, a_pend[0], a_ovr[0]}, 32'h0);
    a_load0(8'h33, 1'b0);
    a_load0(8'h44, 1'b0);
    chk("flag_ovr_again", {30'h0, a_pend[0], a_ovr[0]}, 32'h3);
    a_load0(8'h55, 1'b1);
    chk("flag_load_clr", {30'h0, a_pend[0], a_ovr[0]}, 32'h2);

    // Edge (A ch1) vs level (B): ld held 5 cycles, d stepping each cycle.
    n_edge = 0;
    n_lvl  = 0;
    for (int k = 0; k < 5; k++) begin
      a_d[15:8] = 8'h10 + 8'(k);
      b_d       = 8'h10 + 8'(k);
      a_ld[1]   = 1'b1;
      b_ld      = 1'b1;
      tick();
      if (a_upd[1]) n_edge++;
      if (b_upd[0]) n_lvl++;
    end
    a_ld[1] = 1'b0;
    b_ld    = 1'b0;
    repeat (8) begin
      tick();
      if (a_upd[1]) n_edge++;
      if (b_upd[0]) n_lvl++;
    end
    chk("edge_upd_count", n_edge, 1);
    chk("edge_q", {24'h0, a_q[15:8]}, 32'h12);
    chk("level_upd_count", n_lvl, 5);
    chk("level_q", {24'h0, b_q}, 32'h14);
    chk("edge_ch0_kept", {24'h0, a_q[7:0]}, 32'h55);

    // S=0, level: ld before edge -> q after that edge, not combinationally.
    c_d  = 8'h5A;
    c_ld = 1'b1;
    #1;
    chk("s0_no_comb", {24'h0, c_q}, 32'h0);
    tick();
    chk("s0_q", {24'h0, c_q}, 32'h5A);
    chk("s0_upd_ack", {30'h0, c_upd, c_ack}, 32'h3);
    c_ld = 1'b0;
    tick();
    chk("s0_drop", {30'h0, c_upd, c_ack}, 32'h0);

    // 4-phase traffic on D.
    for (int c = 0; c < 4; c++) begin
      st[c] = 0; wcnt[c] = c; n_req[c] = 0; n_upd[c] = 0; exp_q[c] = 8'h0;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (d_upd[c]) n_upd[c]++;
        case (st[c])
          0: begin
            if (cyc < 440) begin
              if (wcnt[c] == 0) begin
                exp_q[c] = 8'($urandom);
                d_d[c*8 +: 8] = exp_q[c];
                d_ld[c] = 1'b1;
                n_req[c]++;
                st[c] = 1;
              end else begin
                wcnt[c]--;
              end
            end
          end
          1: begin
            if (d_ack[c]) begin
              chk("rnd_q", {24'h0, d_q[c*8 +: 8]}, {24'h0, exp_q[c]});
              d_ld[c] = 1'b0;
              wcnt[c] = 0;
              st[c] = 2;
            end else begin
              wcnt[c]++;
              if (wcnt[c] > 20) begin
                chk("rnd_ack_timeout", {31'h0, d_ack[c]}, 32'h1);
                d_ld[c] = 1'b0;
                wcnt[c] = 0;
                st[c] = 2;
              end
            end
          end
          default: begin
            if (!d_ack[c]) begin
              st[c] = 0;
              wcnt[c] = int'($urandom_range(0, 3));
            end
          end
        endcase
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      chk("rnd_upd_vs_req", n_upd[c], n_req[c]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
